spi_tx_arbiter: RTL and testbench

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_tx_arbiter_if.sv | 35 +++
 rtl/spi_busy_sync.sv | 25 ++
 rtl/spi_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_spi_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit arbiter slice.
// Contents: default parameter values, the arbiter state encoding and a
// small modulo-add helper used for round-robin index arithmetic.
package spi_pkg;

    localparam int unsigned NUM_REQ_DEF     = 4;
    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned ACK_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // (a + b) mod n, valid for a < n and b <= n.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// Requester / transmitter bundle for spi_tx_arbiter.
//   req       per-requester level request, held until its done
//   req_data  per-requester byte, requester i at [i*DATA_W +: DATA_W]
//   gnt       one-hot grant
//   done      one-cycle completion pulse to the granted requester
//   err       one-cycle busy-timeout pulse to the granted requester
//   tx_data   byte presented to the SPI transmitter
//   tx_send   send request to the transmitter
//   tx_busy   transmitter busy (sck domain, asynchronous to clk)
// slave: the arbiter side; master: requesters plus transmitter side.
interface spi_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = spi_pkg::NUM_REQ_DEF,
    parameter int unsigned DATA_W  = spi_pkg::DATA_W_DEF
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_send;
    logic                      tx_busy;

    modport slave (
        input  req, req_data, tx_busy,
        output gnt, done, err, tx_data, tx_send
    );

    modport master (
        output req, req_data, tx_busy,
        input  gnt, done, err, tx_data, tx_send
    );

endinterface

// File: rtl/spi_busy_sync.sv
// Two-flop synchronizer bringing the transmitter busy flag into clk.
//   clk     system clock
//   reset   synchronous active-high reset, clears both flops
//   busy    asynchronous busy from the sck domain
//   busy_s  synchronized busy
module spi_busy_sync (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    output logic busy_s
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            meta   <= busy;
            busy_s <= meta;
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI leader transmitter between NUM_REQ
// requesters. A winner is granted, its byte latched onto tx_data, tx_send
// raised until the transmitter reports busy, then done is pulsed once busy
// clears. If busy never rises within ACK_TIMEOUT cycles, err is pulsed.
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    spi_tx_arbiter_if.slave (req/req_data in, gnt/done/err,
//          tx_data/tx_send out, tx_busy in)
module spi_tx_arbiter import spi_pkg::*; #(
    parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    spi_tx_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT);

    state_t             state;
    state_t             state_nxt;
    logic               busy_s;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   cand;
    logic               sel_hit;
    logic [DATA_W-1:0]  sel_data;
    logic [DATA_W-1:0]  tx_data_q;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         warm;
    logic               timeout;
    logic [NUM_REQ-1:0] gnt_c;
    logic [NUM_REQ-1:0] done_c;
    logic [NUM_REQ-1:0] err_c;
    logic               send_c;

    spi_busy_sync u_busy_sync (
        .clk    (clk),
        .reset  (reset),
        .busy   (bus.tx_busy),
        .busy_s (busy_s)
    );

    // Round-robin: first high req at or after ptr, wrapping.
    always_comb begin
        sel     = '0;
        cand    = '0;
        sel_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'(wrap_add(32'(ptr), i, NUM_REQ));
            if (!sel_hit && bus.req[cand]) begin
                sel_hit = 1'b1;
                sel     = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_c     = '0;
        done_c    = '0;
        err_c     = '0;
        send_c    = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // warm[1] holds off arbitration until the synchronizer
                // reflects the real busy level after reset; otherwise its
                // cleared flops would look like an idle transmitter.
                if (warm[1] && sel_hit && !busy_s) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt_c[winner] = 1'b1;
                state_nxt     = ST_SEND;
            end
            ST_SEND: begin
                gnt_c[winner] = 1'b1;
                send_c        = 1'b1;
                if (busy_s) begin
                    state_nxt = ST_WAIT;
                end else if (cnt == TO_LAST) begin
                    timeout       = 1'b1;
                    err_c[winner] = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            ST_WAIT: begin
                gnt_c[winner] = 1'b1;
                if (!busy_s) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt_c[winner]  = 1'b1;
                done_c[winner] = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            winner    <= '0;
            tx_data_q <= '0;
            cnt       <= '0;
            warm      <= '0;
        end else begin
            state <= state_nxt;
            warm  <= {warm[0], 1'b1};
            if (state == ST_IDLE && state_nxt == ST_GRANT) begin
                winner    <= sel;
                tx_data_q <= sel_data;
            end
            cnt <= (state == ST_SEND) ? cnt + 1'b1 : '0;
            // Advance past the winner on success or timeout alike.
            if (state == ST_DONE || timeout) begin
                ptr <= IDX_W'(wrap_add(32'(winner), 1, NUM_REQ));
            end
        end
    end

    assign bus.gnt     = gnt_c;
    assign bus.done    = done_c;
    assign bus.err     = err_c;
    assign bus.tx_send = send_c;
    assign bus.tx_data = tx_data_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter: stimulus pushes expected done/err
// events; a negedge monitor pops and checks them when the DUT pulses.
module tb_spi_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned ATO  = 255;

    logic clk = 1'b0;
    logic reset;

    spi_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

    spi_tx_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .ACK_TIMEOUT(ATO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_err;
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_exp;
    logic [NREQ-1:0] mon_ev;
    int   mon_idx;

    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    bit   model_on   = 1'b1;
    int   model_dly  = 40;
    int   model_len  = 400;

    assign bus.tx_busy = model_busy | force_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input bit e, input int idx, input logic [7:0] d);
        exp_t x;
        x.is_err = e;
        x.idx    = idx;
        x.data   = d;
        sbq.push_back(x);
    endtask

    task automatic wait_send(input logic val, input int budget, input string name);
        int c = 0;
        while (bus.tx_send !== val && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(bus.tx_send), 32'(val));
    endtask

    task automatic wait_ev(input int n, input int budget, input string name);
        int seen = 0;
        int c = 0;
        while (seen < n && c < budget) begin
            @(negedge clk);
            c++;
            if ((bus.done | bus.err) != '0) seen++;
        end
        check(name, seen, n);
    endtask

    // Transmitter model: busy rises model_dly cycles after send, lasts model_len.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on && bus.tx_send === 1'b1 && !model_busy) begin
                repeat (model_dly) @(negedge clk);
                model_busy = 1'b1;
                repeat (model_len) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!reset && ((bus.done | bus.err) != '0)) begin
            mon_ev  = bus.done | bus.err;
            mon_idx = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (mon_ev[i] && mon_idx < 0) mon_idx = i;
            end
            if (sbq.size() == 0) begin
                check("sb_unexpected", 32'(mon_ev), 0);
            end else begin
                mon_exp = sbq.pop_front();
                check("sb_kind",   32'(bus.err != '0), 32'(mon_exp.is_err));
                check("sb_idx",    mon_idx, mon_exp.idx);
                check("sb_onehot", 32'(mon_ev), 32'(1) << mon_exp.idx);
                check("sb_data",   32'(bus.tx_data), 32'(mon_exp.data));
                check("sb_gnt",    32'(bus.gnt), 32'(1) << mon_exp.idx);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int g;

        reset        = 1'b1;
        bus.req      = '0;
        bus.req_data = 32'h443322A5;
        repeat (3) @(negedge clk);
        check("rst_gnt",  32'(bus.gnt), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err",  32'(bus.err), 0);
        check("rst_send", 32'(bus.tx_send), 0);
        check("rst_data", 32'(bus.tx_data), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single request, A5, busy 40 cycles after send for 400 cycles.
        push(0, 0, 8'hA5);
        bus.req = 4'b0001;
        @(negedge clk);
        check("lat1_send", 32'(bus.tx_send), 0);
        check("lat1_gnt",  32'(bus.gnt), 32'h1);
        check("lat1_data", 32'(bus.tx_data), 32'hA5);
        @(negedge clk);
        check("lat2_send", 32'(bus.tx_send), 1);
        wait_ev(1, 1000, "single_done");
        bus.req = '0;
        @(negedge clk);
        check("single_gnt_fall", 32'(bus.gnt), 0);
        check("single_done_one", 32'(bus.done), 0);

        // Contention from ptr 0: order 0,1,2,3,0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        model_dly    = 4;
        model_len    = 12;
        bus.req_data = 32'h44332211;
        push(0, 0, 8'h11);
        push(0, 1, 8'h22);
        push(0, 2, 8'h33);
        push(0, 3, 8'h44);
        push(0, 0, 8'h11);
        bus.req = 4'b1111;
        wait_ev(5, 500, "cont_done");
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Pointer wrap: grant 3, then 1001 -> 0 then 3.
        push(0, 3, 8'h44);
        bus.req = 4'b1000;
        wait_ev(1, 200, "wrap_first");
        bus.req = 4'b1001;
        push(0, 0, 8'h11);
        push(0, 3, 8'h44);
        wait_ev(2, 300, "wrap_pair");
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Timeout: busy never rises, SEND lasts ATO+1 cycles, err on 2.
        model_on = 1'b0;
        push(1, 2, 8'h33);
        bus.req = 4'b0100;
        wait_send(1'b1, 10, "to_send_rise");
        cnt = 0;
        while (bus.tx_send === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        bus.req = '0;
        check("to_send_len", cnt, ATO + 1);
        model_on = 1'b1;
        repeat (2) @(negedge clk);

        // ptr advanced to 3 after err: 1100 must pick 3, not 2.
        push(0, 3, 8'h44);
        bus.req = 4'b1100;
        wait_ev(1, 300, "to_ptr_adv");
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Reset in WAIT with busy high; pending req waits for busy to fall.
        model_dly = 3;
        model_len = 80;
        bus.req   = 4'b0001;
        wait_send(1'b1, 10, "rw_send_rise");
        wait_send(1'b0, 20, "rw_in_wait");
        reset   = 1'b1;
        bus.req = 4'b0010;
        @(negedge clk);
        check("rw_send", 32'(bus.tx_send), 0);
        check("rw_gnt",  32'(bus.gnt), 0);
        reset = 1'b0;
        g   = 0;
        cnt = 0;
        while (model_busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (bus.gnt != '0) g++;
        end
        check("rw_no_grant", g, 0);
        push(0, 1, 8'h22);
        wait_ev(1, 200, "rw_done");
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Requester drops req during WAIT: done still issued.
        model_len = 20;
        push(0, 2, 8'h33);
        bus.req = 4'b0100;
        wait_send(1'b1, 10, "dw_send_rise");
        wait_send(1'b0, 20, "dw_in_wait");
        bus.req = '0;
        wait_ev(1, 200, "dw_done");
        repeat (3) @(negedge clk);

        // Busy already high when req arrives: no grant until it falls.
        force_busy = 1'b1;
        repeat (4) @(negedge clk);
        bus.req = 4'b0001;
        g = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.gnt != '0) g++;
        end
        check("bh_no_grant", g, 0);
        push(0, 0, 8'h11);
        force_busy = 1'b0;
        wait_ev(1, 200, "bh_done");
        bus.req = '0;
        repeat (3) @(negedge clk);

        check("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
